// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_SCALAR = 2'd1,
    KIND_VECTOR = 2'd2,
    KIND_HIST   = 2'd3
  } kind_e;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_e;

  localparam int SB_DEPTH = 3;
  localparam int BR_LAT   = 2;

  typedef struct packed {
    logic       valid;
    kind_e      kind;
    logic [5:0] index;
  } entry_t;

  function automatic logic entry_match(input entry_t src, input entry_t ent);
    return src.valid && ent.valid && (src.kind == ent.kind) && (src.index == ent.index);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W destination shadow and source compare
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  entry_t dest,
  input  logic   flush_m,
  input  entry_t src_a,
  input  entry_t src_b,
  input  entry_t src_v,
  input  entry_t src_h,
  output logic   hazard
);

  // Index 0 = E, 1 = M, 2 = W.
  entry_t sb [SB_DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= dest;
      sb[1] <= flush_m ? entry_t'('0) : sb[0];
      sb[2] <= sb[1];
    end
  end

  // W is included because the register file write lands at the end of that cycle.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      hazard = hazard | entry_match(src_a, sb[i]) | entry_match(src_b, sb[i])
                      | entry_match(src_v, sb[i]) | entry_match(src_h, sb[i]);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline stall/flush control with branch wait FSM
module hazard_controller
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_D,
  input  logic [2:0]  RnSA_D,
  input  logic [2:0]  RnSB_D,
  input  logic        useA_D,
  input  logic        useB_D,
  input  logic        RvS_D,
  input  logic        useV_D,
  input  logic [5:0]  RhS_D,
  input  logic        useH_D,
  input  logic        ScalarWrite_D,
  input  logic        VectorWrite_D,
  input  logic        HistogramWrite_D,
  input  logic [2:0]  RnD_D,
  input  logic        RvD_D,
  input  logic [5:0]  RhD_D,
  input  logic        Branch_D,
  input  logic        PCSrc_W,
  output logic        enable_F,
  output logic        enable_FtoD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        FlushW,
  output logic [15:0] stall_count
);

  state_e     state, next_state;
  logic [1:0] br_cnt, next_br_cnt;
  logic       hazard, stall;
  entry_t     dest, src_a, src_b, src_v, src_h;

  always_comb begin
    src_a = '0;
    src_b = '0;
    src_v = '0;
    src_h = '0;
    src_a.valid = valid_D & useA_D;
    src_a.kind  = KIND_SCALAR;
    src_a.index = {3'b000, RnSA_D};
    src_b.valid = valid_D & useB_D;
    src_b.kind  = KIND_SCALAR;
    src_b.index = {3'b000, RnSB_D};
    src_v.valid = valid_D & useV_D;
    src_v.kind  = KIND_VECTOR;
    src_v.index = {5'b00000, RvS_D};
    src_h.valid = valid_D & useH_D;
    src_h.kind  = KIND_HIST;
    src_h.index = RhS_D;
  end

  always_comb begin
    dest = '0;
    if (valid_D && !FlushE) begin
      if (ScalarWrite_D) begin
        dest.valid = 1'b1;
        dest.kind  = KIND_SCALAR;
        dest.index = {3'b000, RnD_D};
      end else if (VectorWrite_D) begin
        dest.valid = 1'b1;
        dest.kind  = KIND_VECTOR;
        dest.index = {5'b00000, RvD_D};
      end else if (HistogramWrite_D) begin
        dest.valid = 1'b1;
        dest.kind  = KIND_HIST;
        dest.index = RhD_D;
      end
    end
  end

  hazard_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .dest    (dest),
    .flush_m (FlushM),
    .src_a   (src_a),
    .src_b   (src_b),
    .src_v   (src_v),
    .src_h   (src_h),
    .hazard  (hazard)
  );

  // A PC write from W outranks a data hazard: everything younger is wrong-path.
  assign stall = reset && (state == ST_RUN) && !PCSrc_W && hazard;

  always_comb begin
    enable_F    = 1'b1;
    enable_FtoD = 1'b1;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;
    next_state  = state;
    next_br_cnt = br_cnt;
    if (!reset) begin
      enable_F    = 1'b0;
      enable_FtoD = 1'b0;
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      FlushM      = 1'b1;
      FlushW      = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (PCSrc_W) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
          end else if (hazard) begin
            enable_F    = 1'b0;
            enable_FtoD = 1'b0;
            FlushE      = 1'b1;
          end else if (valid_D && Branch_D) begin
            enable_F    = 1'b0;
            FlushD      = 1'b1;
            next_state  = ST_BR_WAIT;
            next_br_cnt = 2'd0;
          end
        end
        ST_BR_WAIT: begin
          if (br_cnt == 2'(BR_LAT)) begin
            FlushD      = PCSrc_W;
            next_state  = ST_RUN;
            next_br_cnt = 2'd0;
          end else begin
            enable_F    = 1'b0;
            FlushD      = 1'b1;
            next_br_cnt = br_cnt + 2'd1;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      br_cnt      <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      state  <= next_state;
      br_cnt <= next_br_cnt;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_D;
  logic [2:0]  RnSA_D, RnSB_D;
  logic        useA_D, useB_D;
  logic        RvS_D, useV_D;
  logic [5:0]  RhS_D;
  logic        useH_D;
  logic        ScalarWrite_D, VectorWrite_D, HistogramWrite_D;
  logic [2:0]  RnD_D;
  logic        RvD_D;
  logic [5:0]  RhD_D;
  logic        Branch_D, PCSrc_W;
  logic        enable_F, enable_FtoD, FlushD, FlushE, FlushM, FlushW;
  logic [15:0] stall_count;
  logic [5:0]  ctl;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign ctl = {enable_F, enable_FtoD, FlushD, FlushE, FlushM, FlushW};

  // ctl expectation encoding: {enable_F, enable_FtoD, FlushD, FlushE, FlushM, FlushW}
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_BRWAIT = 6'b011000;
  localparam logic [5:0] C_TAKEN  = 6'b111000;
  localparam logic [5:0] C_REDIR  = 6'b111110;
  localparam logic [5:0] C_RESET  = 6'b001111;

  hazard_controller dut (
    .clk              (clk),
    .reset            (reset),
    .valid_D          (valid_D),
    .RnSA_D           (RnSA_D),
    .RnSB_D           (RnSB_D),
    .useA_D           (useA_D),
    .useB_D           (useB_D),
    .RvS_D            (RvS_D),
    .useV_D           (useV_D),
    .RhS_D            (RhS_D),
    .useH_D           (useH_D),
    .ScalarWrite_D    (ScalarWrite_D),
    .VectorWrite_D    (VectorWrite_D),
    .HistogramWrite_D (HistogramWrite_D),
    .RnD_D            (RnD_D),
    .RvD_D            (RvD_D),
    .RhD_D            (RhD_D),
    .Branch_D         (Branch_D),
    .PCSrc_W          (PCSrc_W),
    .enable_F         (enable_F),
    .enable_FtoD      (enable_FtoD),
    .FlushD           (FlushD),
    .FlushE           (FlushE),
    .FlushM           (FlushM),
    .FlushW           (FlushW),
    .stall_count      (stall_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    reset = 1'b1; valid_D = 1'b0;
    RnSA_D = 3'd0; RnSB_D = 3'd0; useA_D = 1'b0; useB_D = 1'b0;
    RvS_D = 1'b0; useV_D = 1'b0; RhS_D = 6'd0; useH_D = 1'b0;
    ScalarWrite_D = 1'b0; VectorWrite_D = 1'b0; HistogramWrite_D = 1'b0;
    RnD_D = 3'd0; RvD_D = 1'b0; RhD_D = 6'd0;
    Branch_D = 1'b0; PCSrc_W = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    settle();
    chk("reset_ctl", 16'(ctl), 16'(C_RESET));
    tick();
    tick();
    chk("reset_ctl_hold", 16'(ctl), 16'(C_RESET));
    chk("reset_stall_count", stall_count, 16'd0);

    idle();
    settle();
    chk("run_idle_ctl", 16'(ctl), 16'(C_RUN));
    tick();

    // scalar write r3 then read r3: three stalls (E, M, W)
    idle(); valid_D = 1'b1; ScalarWrite_D = 1'b1; RnD_D = 3'd3;
    settle();
    chk("raw_write_ctl", 16'(ctl), 16'(C_RUN));
    tick();
    idle(); valid_D = 1'b1; useA_D = 1'b1; RnSA_D = 3'd3;
    settle();
    chk("raw_stall_e", 16'(ctl), 16'(C_STALL));
    tick();
    chk("raw_stall_m", 16'(ctl), 16'(C_STALL));
    tick();
    chk("raw_stall_w", 16'(ctl), 16'(C_STALL));
    tick();
    chk("raw_issue", 16'(ctl), 16'(C_RUN));
    chk("raw_stall_count", stall_count, 16'd3);
    tick();
    idle();
    tick(); tick(); tick();

    // independent write r3, read r5 (unused B port names r3)
    idle(); valid_D = 1'b1; ScalarWrite_D = 1'b1; RnD_D = 3'd3;
    tick();
    idle(); valid_D = 1'b1; useA_D = 1'b1; RnSA_D = 3'd5; RnSB_D = 3'd3;
    settle();
    chk("indep_ctl", 16'(ctl), 16'(C_RUN));
    tick();
    chk("indep_stall_count", stall_count, 16'd3);
    idle();
    tick(); tick(); tick();

    // scalar r1 written, vector v1 read: kinds differ, no hazard
    idle(); valid_D = 1'b1; ScalarWrite_D = 1'b1; RnD_D = 3'd1;
    tick();
    idle(); valid_D = 1'b1; useV_D = 1'b1; RvS_D = 1'b1;
    settle();
    chk("kind_mismatch_ctl", 16'(ctl), 16'(C_RUN));
    tick();
    idle();
    tick(); tick(); tick();

    // taken branch: enable_F low 3 cycles, FlushD high 4 cycles
    idle(); valid_D = 1'b1; Branch_D = 1'b1;
    settle();
    chk("tbr_issue", 16'(ctl), 16'(C_BRWAIT));
    tick();
    idle();
    settle();
    chk("tbr_cnt0", 16'(ctl), 16'(C_BRWAIT));
    tick();
    chk("tbr_cnt1", 16'(ctl), 16'(C_BRWAIT));
    tick();
    PCSrc_W = 1'b1;
    settle();
    chk("tbr_w_taken", 16'(ctl), 16'(C_TAKEN));
    tick();
    idle();
    settle();
    chk("tbr_back_run", 16'(ctl), 16'(C_RUN));
    tick();

    // not-taken branch: branch+4 enters D after W cycle
    idle(); valid_D = 1'b1; Branch_D = 1'b1;
    settle();
    chk("nbr_issue", 16'(ctl), 16'(C_BRWAIT));
    tick();
    idle();
    tick();
    tick();
    settle();
    chk("nbr_w_not_taken", 16'(ctl), 16'(C_RUN));
    tick();
    idle(); valid_D = 1'b1;
    settle();
    chk("nbr_next_in_d", 16'(ctl), 16'(C_RUN));
    tick();

    // PC write from W in RUN flushes E and M entries
    idle(); valid_D = 1'b1; ScalarWrite_D = 1'b1; RnD_D = 3'd4;
    tick();
    idle(); valid_D = 1'b1; ScalarWrite_D = 1'b1; RnD_D = 3'd3; PCSrc_W = 1'b1;
    settle();
    chk("redirect_ctl", 16'(ctl), 16'(C_REDIR));
    tick();
    idle(); valid_D = 1'b1; useA_D = 1'b1; RnSA_D = 3'd4; useB_D = 1'b1; RnSB_D = 3'd3;
    settle();
    chk("redirect_sb_cleared", 16'(ctl), 16'(C_RUN));
    tick();
    idle();
    tick(); tick(); tick();

    // histogram h42 write, then branch reading h42: stalls first, then branch
    idle(); valid_D = 1'b1; HistogramWrite_D = 1'b1; RhD_D = 6'd42;
    tick();
    idle(); valid_D = 1'b1; Branch_D = 1'b1; useH_D = 1'b1; RhS_D = 6'd42;
    settle();
    chk("hbr_stall_e", 16'(ctl), 16'(C_STALL));
    tick();
    chk("hbr_stall_m", 16'(ctl), 16'(C_STALL));
    tick();
    chk("hbr_stall_w", 16'(ctl), 16'(C_STALL));
    tick();
    chk("hbr_issue", 16'(ctl), 16'(C_BRWAIT));
    chk("hbr_stall_count", stall_count, 16'd6);
    tick();
    idle();
    settle();
    chk("hbr_cnt0", 16'(ctl), 16'(C_BRWAIT));
    tick();
    chk("hbr_cnt1", 16'(ctl), 16'(C_BRWAIT));
    tick();
    chk("hbr_w", 16'(ctl), 16'(C_RUN));
    tick();

    // reset mid-branch (br_cnt=1) with a scalar write r6 in flight
    idle(); valid_D = 1'b1; Branch_D = 1'b1; ScalarWrite_D = 1'b1; RnD_D = 3'd6;
    tick();
    idle();
    tick();
    reset = 1'b0;
    settle();
    chk("midbr_reset_ctl", 16'(ctl), 16'(C_RESET));
    tick();
    idle(); valid_D = 1'b1; useA_D = 1'b1; RnSA_D = 3'd6;
    settle();
    chk("midbr_after_reset_run", 16'(ctl), 16'(C_RUN));
    chk("midbr_stall_count", stall_count, 16'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have valid_D, input, 1, decode stage holds a real (non-bubble) instruction.
REQ-004 SHALL have RnSA_D/RnSB_D, input, 3 each, scalar source indices; useA_D/useB_D, input, 1 each, source actually read.
REQ-005 SHALL have RvS_D, input, 1, vector source; useV_D, input, 1; RhS_D, input, 6, histogram source; useH_D, input, 1.
REQ-006 SHALL have ScalarWrite_D/VectorWrite_D/HistogramWrite_D, input, 1 each; RnD_D 3, RvD_D 1, RhD_D 6, inputs, destination indices.
REQ-007 SHALL have Branch_D, input, 1, decode instruction is a branch; PCSrc_W, input, 1, writeback redirects PC.
REQ-008 SHALL have enable_F, output, 1, PC register enable; enable_FtoD, output, 1, F/D pipe enable.
REQ-009 SHALL have FlushD/FlushE/FlushM/FlushW, output, 1 each, bubble insert into D/E/M/W pipe registers.
REQ-010 SHALL have stall_count, output, 16, saturating count of data-stall cycles.

Function
REQ-011 SHALL keep a 3-entry shadow scoreboard (E,M,W) of {valid, kind none/scalar/vector/hist, index[5:0]}, shifting E->M->W every cycle.
REQ-012 SHALL load entry E each cycle with the decode destination if valid_D and not stalling and not FlushE; otherwise load invalid.
REQ-013 SHALL flag data hazard when any used decode source matches kind and index of any valid E, M or W entry (W included: RF write lands at cycle end).
REQ-014 Data hazard (state RUN) SHALL drive enable_F=0, enable_FtoD=0, FlushE=1; increment stall_count, saturating at 16'hFFFF.
REQ-015 FSM states RUN, BR_WAIT; 2-bit counter br_cnt.
REQ-016 RUN, valid_D & Branch_D & no hazard: enable_F=0, FlushD=1, go BR_WAIT, br_cnt=0 (branch issues to E).
REQ-017 BR_WAIT, br_cnt 0..1: enable_F=0, enable_FtoD=1, FlushD=1; br_cnt increments.
REQ-018 BR_WAIT, br_cnt=2 (branch in W): enable_F=1, enable_FtoD=1, FlushD=PCSrc_W; return RUN.
REQ-019 Not-taken branch SHALL therefore lose exactly 3 cycles; taken branch 4; held fetch of branch+4 passes to D when not taken.
REQ-020 PCSrc_W=1 in RUN (non-branch PC write) SHALL assert FlushD, FlushE, FlushM for one cycle and invalidate scoreboard E and M entries.
REQ-021 Data hazard and branch simultaneous: hazard wins; branch waits in D, FSM stays RUN.
REQ-022 No hazard, RUN: enable_F=1, enable_FtoD=1, all flushes 0.
REQ-023 FlushW SHALL be 0 except during reset.
REQ-024 Control outputs SHALL be combinational from FSM, scoreboard and inputs; no added latency.

Reset
REQ-025 reset=0 at a clk edge SHALL clear scoreboard valids, FSM to RUN, br_cnt=0, stall_count=0, regardless of state mid-branch or mid-stall.
REQ-026 While reset=0, outputs SHALL be enable_F=0, enable_FtoD=0, FlushD=FlushE=FlushM=FlushW=1.

Structure
REQ-027 hazard_pkg SHALL hold dest-kind enum, FSM state enum, SB_DEPTH=3, BR_LAT=2, entry struct typedef.
REQ-028 Scoreboard shift register and compare logic SHALL be sub-module hazard_scoreboard; FSM and counter in top.

Verification
REQ-029 Scalar write r3 then read r3 back-to-back -> 3 stall cycles (FlushE=1, enable_F=0), issue on 4th, stall_count=3.
REQ-030 Independent write r3, read r5 -> zero stalls, all flushes 0.
REQ-031 Branch, PCSrc_W=1 -> enable_F low 3 cycles, FlushD high 4 cycles, PC target fetched next.
REQ-032 Branch, PCSrc_W=0 -> FlushD=0 on W cycle, instruction at branch+4 enters D.
REQ-033 Histogram write index 42 then read 42 while branch pending -> stall then branch sequence, no overlap.
REQ-034 reset=0 during BR_WAIT br_cnt=1 -> next cycle RUN, scoreboard empty, stall_count=0.
